i2c_slave_tx: RTL and testbench

I2C_SLAVE_TX -- requirements
Module: i2c_slave_tx

---
 rtl/i2c_slave_tx.sv | 171 +++++++++++++++++
 tb/tb_i2c_slave_tx.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_tx.sv
// I2C read-only slave: matches its own address with R/W=1, then shifts out bytes
// supplied on tx_data (or DEFAULT_DATA on underrun) until the master NACKs.
module i2c_slave_tx #(
    parameter logic [7:0] DEFAULT_DATA = 8'hFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic [6:0] slave_addr,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       underrun,
    output logic       busy,
    output logic       done
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        TX_BYTE,
        WAIT_ACK,
        IGNORE
    } state_t;

    state_t           state;
    logic [1:0]       scl_sync;
    logic [1:0]       sda_sync;
    logic             scl_d;
    logic             sda_d;
    logic [CNT_W-1:0] bit_cnt;
    logic [7:0]       shift_reg;
    logic             ack_seen;

    logic scl_s_c;
    logic sda_s_c;
    logic start_c;
    logic stop_c;
    logic rise_c;
    logic fall_c;
    logic [7:0] load_byte_c;

    // Two-flop synchronizers plus one delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl_in};
            sda_sync <= {sda_sync[0], sda_in};
            scl_d    <= scl_sync[1];
            sda_d    <= sda_sync[1];
        end
    end

    // Bus condition decode from synchronized and delayed line levels.
    always_comb begin
        scl_s_c     = scl_sync[1];
        sda_s_c     = sda_sync[1];
        start_c     = scl_s_c & scl_d & sda_d & ~sda_s_c;
        stop_c      = scl_s_c & scl_d & ~sda_d & sda_s_c;
        rise_c      = scl_s_c & ~scl_d;
        fall_c      = ~scl_s_c & scl_d;
        load_byte_c = tx_valid ? tx_data : DEFAULT_DATA;
    end

    // Protocol state machine with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
            ack_seen  <= 1'b0;
            sda_oe    <= 1'b0;
            tx_ready  <= 1'b0;
            underrun  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            tx_ready <= 1'b0;
            underrun <= 1'b0;
            done     <= 1'b0;

            if (start_c) begin
                state    <= ADDR;
                bit_cnt  <= '0;
                ack_seen <= 1'b0;
                sda_oe   <= 1'b0;
                busy     <= 1'b0;
            end else if (stop_c) begin
                state    <= IDLE;
                bit_cnt  <= '0;
                ack_seen <= 1'b0;
                sda_oe   <= 1'b0;
                busy     <= 1'b0;
            end else begin
                case (state)
                    ADDR: begin
                        if (rise_c && bit_cnt < CNT_W'(8)) begin
                            shift_reg <= {shift_reg[6:0], sda_s_c};
                            bit_cnt   <= bit_cnt + CNT_W'(1);
                        end else if (fall_c && bit_cnt == CNT_W'(8)) begin
                            bit_cnt <= '0;
                            if (shift_reg[7:1] == slave_addr && shift_reg[0]) begin
                                sda_oe <= 1'b1;
                                busy   <= 1'b1;
                                state  <= ADDR_ACK;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= IGNORE;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (fall_c) begin
                            shift_reg <= load_byte_c;
                            sda_oe    <= ~load_byte_c[7];
                            tx_ready  <= tx_valid;
                            underrun  <= ~tx_valid;
                            bit_cnt   <= '0;
                            state     <= TX_BYTE;
                        end
                    end
                    TX_BYTE: begin
                        if (fall_c) begin
                            if (bit_cnt == CNT_W'(7)) begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= '0;
                                state   <= WAIT_ACK;
                            end else begin
                                shift_reg <= {shift_reg[6:0], 1'b0};
                                sda_oe    <= ~shift_reg[6];
                                bit_cnt   <= bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                    WAIT_ACK: begin
                        if (rise_c) begin
                            if (sda_s_c) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= IGNORE;
                            end else begin
                                ack_seen <= 1'b1;
                            end
                        end else if (fall_c && ack_seen) begin
                            ack_seen  <= 1'b0;
                            shift_reg <= load_byte_c;
                            sda_oe    <= ~load_byte_c[7];
                            tx_ready  <= tx_valid;
                            underrun  <= ~tx_valid;
                            bit_cnt   <= '0;
                            state     <= TX_BYTE;
                        end
                    end
                    default: begin
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_tx.sv
// Bit-banging I2C master bench for i2c_slave_tx with a transaction-level model.
module tb_i2c_slave_tx;

    localparam int H = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic       sda_oe;
    logic [6:0] slave_addr = 7'h50;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       underrun;
    logic       busy;
    logic       done;

    int total = 0;
    int bad = 0;

    int rdy_cnt = 0;
    int und_cnt = 0;
    int done_cnt = 0;
    int oe_cnt = 0;
    int busy_cnt = 0;
    int both_cnt = 0;

    logic [7:0] q_data [0:3];
    logic       q_valid[0:3];

    assign sda_line = sda_m & ~sda_oe;

    i2c_slave_tx dut (
        .clk       (clk),
        .reset     (reset),
        .scl_in    (scl),
        .sda_in    (sda_line),
        .sda_oe    (sda_oe),
        .slave_addr(slave_addr),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .underrun  (underrun),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Pulse and level activity counters.
    always @(posedge clk) begin
        rdy_cnt  <= rdy_cnt + (tx_ready ? 1 : 0);
        und_cnt  <= und_cnt + (underrun ? 1 : 0);
        done_cnt <= done_cnt + (done ? 1 : 0);
        oe_cnt   <= oe_cnt + (sda_oe ? 1 : 0);
        busy_cnt <= busy_cnt + (busy ? 1 : 0);
        both_cnt <= both_cnt + ((tx_ready && underrun) ? 1 : 0);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_h();
        repeat (H) @(negedge clk);
    endtask

    task automatic start_cond();
        scl = 1'b1; sda_m = 1'b1; wait_h();
        sda_m = 1'b0; wait_h();
        scl = 1'b0; wait_h();
    endtask

    task automatic rep_start();
        sda_m = 1'b1; wait_h();
        scl = 1'b1; wait_h();
        sda_m = 1'b0; wait_h();
        scl = 1'b0; wait_h();
    endtask

    task automatic stop_cond();
        sda_m = 1'b0; wait_h();
        scl = 1'b1; wait_h();
        sda_m = 1'b1; wait_h();
        wait_h();
    endtask

    task automatic write_bit(input logic b);
        sda_m = b; wait_h();
        scl = 1'b1; wait_h(); wait_h();
        scl = 1'b0; wait_h();
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; wait_h();
        scl = 1'b1; wait_h();
        b = sda_line; wait_h();
        scl = 1'b0; wait_h();
    endtask

    task automatic write_byte(input logic [7:0] v, output logic ack_bit);
        for (int i = 7; i >= 0; i--) write_bit(v[i]);
        read_bit(ack_bit);
    endtask

    task automatic read_byte(output logic [7:0] v);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            v[i] = b;
        end
    endtask

    // Full read of n bytes from q_data/q_valid; master NACKs the last byte.
    task automatic read_txn(input string tag, input int n);
        logic       ack_bit;
        logic [7:0] got;
        logic [7:0] exp;
        int r0, u0, d0, nv;
        r0 = rdy_cnt; u0 = und_cnt; d0 = done_cnt; nv = 0;
        tx_data = q_data[0]; tx_valid = q_valid[0];
        start_cond();
        write_byte({slave_addr, 1'b1}, ack_bit);
        check({tag, "_addr_ack"}, 32'(ack_bit), 32'd0);
        check({tag, "_busy_on"}, 32'(busy), 32'd1);
        for (int k = 0; k < n; k++) begin
            read_byte(got);
            exp = q_valid[k] ? q_data[k] : 8'hFF;
            if (q_valid[k]) nv++;
            check({tag, "_byte"}, 32'(got), 32'(exp));
            if (k < n - 1) begin
                tx_data = q_data[k+1]; tx_valid = q_valid[k+1];
                write_bit(1'b0);
            end else begin
                write_bit(1'b1);
            end
        end
        check({tag, "_done"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_busy_off"}, 32'(busy), 32'd0);
        check({tag, "_oe_off"}, 32'(sda_oe), 32'd0);
        stop_cond();
        check({tag, "_tx_ready"}, 32'(rdy_cnt - r0), 32'(nv));
        check({tag, "_underrun"}, 32'(und_cnt - u0), 32'(n - nv));
    endtask

    // Transaction the slave must not respond to at all.
    task automatic ignore_txn(input string tag, input logic [7:0] abyte);
        logic       ack_bit;
        logic [7:0] got;
        int o0, b0, r0, u0;
        o0 = oe_cnt; b0 = busy_cnt; r0 = rdy_cnt; u0 = und_cnt;
        tx_data = 8'h5A; tx_valid = 1'b1;
        start_cond();
        write_byte(abyte, ack_bit);
        check({tag, "_nack"}, 32'(ack_bit), 32'd1);
        read_byte(got);
        check({tag, "_released"}, 32'(got), 32'hFF);
        write_bit(1'b1);
        stop_cond();
        check({tag, "_oe_cnt"}, 32'(oe_cnt - o0), 32'd0);
        check({tag, "_busy_cnt"}, 32'(busy_cnt - b0), 32'd0);
        check({tag, "_pulses"}, 32'((rdy_cnt - r0) + (und_cnt - u0)), 32'd0);
    endtask

    initial begin
        logic       ack_bit;
        logic       b;
        logic [7:0] got;
        logic [7:0] abyte;
        int d0, r0, n;

        // Reset state
        repeat (4) @(negedge clk);
        check("rst_sda_oe", 32'(sda_oe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Two-byte read, ACK then NACK
        q_data[0] = 8'hA5; q_valid[0] = 1'b1;
        q_data[1] = 8'h3C; q_valid[1] = 1'b1;
        read_txn("two_byte", 2);

        // Non-matching address and write direction are ignored
        ignore_txn("addr51", 8'hA3);
        ignore_txn("write", 8'hA0);

        // Underrun supplies the default byte
        q_data[0] = 8'h12; q_valid[0] = 1'b0;
        read_txn("underrun", 1);

        // Latency check and reset in the middle of a data byte
        tx_data = 8'hA5; tx_valid = 1'b1;
        start_cond();
        write_byte(8'hA1, ack_bit);
        check("mid_addr_ack", 32'(ack_bit), 32'd0);
        read_bit(b);
        check("mid_bit7", 32'(b), 32'd1);
        read_bit(b);
        check("mid_bit6", 32'(b), 32'd0);
        sda_m = 1'b1; wait_h();
        scl = 1'b1; wait_h(); wait_h();
        scl = 1'b0;
        @(negedge clk); @(negedge clk);
        check("lat_before", 32'(sda_oe), 32'd0);
        @(negedge clk);
        check("lat_after", 32'(sda_oe), 32'd1);
        repeat (H - 3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_oe", 32'(sda_oe), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        wait_h();
        stop_cond();
        q_data[0] = 8'h5A; q_valid[0] = 1'b1;
        read_txn("after_rst", 1);

        // Repeated START after first byte
        d0 = done_cnt; r0 = rdy_cnt;
        tx_data = 8'hA5; tx_valid = 1'b1;
        start_cond();
        write_byte(8'hA1, ack_bit);
        check("rs_ack1", 32'(ack_bit), 32'd0);
        read_byte(got);
        check("rs_byte1", 32'(got), 32'hA5);
        tx_data = 8'h3C;
        write_bit(1'b1);
        rep_start();
        check("rs_busy_cleared", 32'(busy), 32'd0);
        write_byte(8'hA1, ack_bit);
        check("rs_ack2", 32'(ack_bit), 32'd0);
        check("rs_busy2", 32'(busy), 32'd1);
        read_byte(got);
        check("rs_byte2", 32'(got), 32'h3C);
        write_bit(1'b1);
        stop_cond();
        check("rs_busy_end", 32'(busy), 32'd0);
        check("rs_tx_ready", 32'(rdy_cnt - r0), 32'd2);
        check("rs_done", 32'(done_cnt - d0), 32'd2);

        // Randomized transactions
        for (int it = 0; it < 8; it++) begin
            slave_addr = 7'($urandom);
            n = $urandom_range(1, 3);
            for (int k = 0; k < 4; k++) begin
                q_data[k]  = 8'($urandom);
                q_valid[k] = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 3) != 0) begin
                read_txn("rand_read", n);
            end else begin
                if ($urandom_range(0, 1) == 0)
                    abyte = {slave_addr, 1'b0};
                else
                    abyte = {slave_addr ^ 7'(1 << $urandom_range(0, 6)), 1'b1};
                ignore_txn("rand_ign", abyte);
            end
        end

        check("never_both", 32'(both_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
